// File: rtl/alu_exec_unit.sv
// Two-stage elastic ALU pipeline (ADD/SUB/AND/OR/SLT) with a downstream transfer counter.
// Optional signed-overflow output is built when ALU_EXEC_OVERFLOW_EN is defined.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [15:0]      op_count
`ifdef ALU_EXEC_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam int         MSB    = WIDTH - 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; each stage loads when it is empty or its contents leave on the same edge.
    logic             s1_valid;
    logic [2:0]       s1_ctrl;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_valid;
    logic             s2_ready;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] nxt_result;
    logic             nxt_zero;
    logic             nxt_illegal;

    assign s2_ready  = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_ready;
    assign out_valid = s2_valid;

    always_comb begin
        sum         = s1_a + s1_b;
        diff        = s1_a - s1_b;
        nxt_result  = '0;
        nxt_illegal = 1'b0;
        case (s1_ctrl)
            OP_ADD:  nxt_result = sum;
            OP_SUB:  nxt_result = diff;
            OP_AND:  nxt_result = s1_a & s1_b;
            OP_OR:   nxt_result = s1_a | s1_b;
            OP_SLT:  nxt_result = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            default: nxt_illegal = 1'b1;
        endcase
        nxt_zero = (nxt_result == '0);
    end

`ifdef ALU_EXEC_OVERFLOW_EN
    logic nxt_overflow;

    // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips.
    always_comb begin
        nxt_overflow = 1'b0;
        case (s1_ctrl)
            OP_ADD:  nxt_overflow = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
            OP_SUB:  nxt_overflow = (s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
            default: nxt_overflow = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (s2_ready && s1_valid) begin
            overflow <= nxt_overflow;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_ctrl  <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_ctrl <= alu_control;
                s1_a    <= a;
                s1_b    <= b;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            illegal  <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result  <= nxt_result;
                zero    <= nxt_zero;
                illegal <= nxt_illegal;
            end
        end
    end

    // Counts downstream transfers; natural 16-bit wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_count <= '0;
        end else if (s2_valid && out_ready) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule
